// File: rtl/ring_nic.sv
// Ring network interface: one-entry input and output packet buffers exposed to the
// processor as four 64-bit registers, with a VC-polarity-gated send/ready router handshake.
module ring_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity
);

    typedef enum logic [1:0] {
        REG_IN_BUF     = 2'b00,
        REG_IN_STATUS  = 2'b01,
        REG_OUT_BUF    = 2'b10,
        REG_OUT_STATUS = 2'b11
    } reg_sel_e;

    logic [0:63] in_buf_q,  in_buf_d;
    logic        in_full_q, in_full_d;
    logic [0:63] out_buf_q,  out_buf_d;
    logic        out_full_q, out_full_d;
    logic [0:63] d_out_q,   d_out_d;

    logic     rd_en;
    logic     wr_en;
    reg_sel_e sel;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;
    assign sel   = reg_sel_e'(addr);

    assign net_ri = ~in_full_q;
    // Packet bit 0 (the MSB here) carries the virtual channel the packet travels on.
    assign net_so = out_full_q & net_ro & (out_buf_q[0] == net_polarity);
    assign net_do = out_buf_q;
    assign d_out  = d_out_q;

    always_comb begin
        // NOTE: every _d starts at its current _q so no path leaves it unassigned (no latches).
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        d_out_d    = d_out_q;

        if (net_si && net_ri) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end

        if (rd_en) begin
            unique case (sel)
                REG_IN_BUF: begin
                    d_out_d = in_buf_q;
                    if (in_full_q) in_full_d = 1'b0;
                end
                REG_IN_STATUS:  d_out_d = {63'b0, in_full_q};
                REG_OUT_BUF:    d_out_d = out_buf_q;
                REG_OUT_STATUS: d_out_d = {63'b0, out_full_q};
            endcase
        end

        // A store into a full output buffer is dropped; a send can only happen while full,
        // so the two updates below never collide.
        if (wr_en && sel == REG_OUT_BUF && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end

        if (net_so) out_full_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
            d_out_q    <= '0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            d_out_q    <= d_out_d;
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Directed, table-driven bench for ring_nic with hand-written sequences for the
// polarity wait and reset-mid-transfer corners.
module tb_ring_nic;

    logic        clk;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;

    ring_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic        we;
        logic [1:0]  addr;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic        exp_ri;
        logic        exp_so;
        logic [63:0] exp_do;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] P1   = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] P2   = 64'hDEAD_BEEF_0000_0007;
    localparam logic [63:0] PS   = 64'h8000_0000_0000_00FF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic we, input logic [1:0] a, input logic [63:0] din,
                       input logic si, input logic [63:0] di, input logic ro, input logic pol,
                       input logic exp_ri, input logic exp_so, input logic [63:0] exp_do,
                       input logic [63:0] exp_dout);
        vec_t v;
        v.en = en; v.we = we; v.addr = a; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.exp_ri = exp_ri; v.exp_so = exp_so;
        v.exp_do = exp_do; v.exp_dout = exp_dout;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic we, input logic [1:0] a, input logic [63:0] din,
                         input logic si, input logic [63:0] di, input logic ro, input logic pol);
        nicEn = en; nicWrEn = we; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    endtask

    // Drive at the falling edge, check router outputs before the rising edge and d_out after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.en, v.we, v.addr, v.din, v.si, v.di, v.ro, v.pol);
        #1;
        check($sformatf("v%0d net_ri", idx), 64'(net_ri), 64'(v.exp_ri));
        check($sformatf("v%0d net_so", idx), 64'(net_so), 64'(v.exp_so));
        check($sformatf("v%0d net_do", idx), net_do, v.exp_do);
        @(posedge clk);
        #1;
        check($sformatf("v%0d d_out", idx), d_out, v.exp_dout);
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [63:0] exp, input string name);
        @(negedge clk);
        drive(1'b1, 1'b0, a, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check(name, d_out, exp);
    endtask

    initial begin
        int so_count;
        int first_so;
        logic so_pol;

        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset asserted between edges takes effect with no clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst d_out", d_out, 64'h0);
        check("async_rst net_ri", 64'(net_ri), 64'h1);
        check("async_rst net_so", 64'(net_so), 64'h0);
        check("async_rst net_do", net_do, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        //  en we addr din   si di   ro pol  ri so do  dout
        add(1, 0, 2'b01, 0,    0, 0,   0, 0,  1, 0, 0,  0);
        add(1, 0, 2'b11, 0,    0, 0,   0, 0,  1, 0, 0,  0);
        add(0, 0, 2'b00, 0,    1, P1,  0, 0,  1, 0, 0,  0);
        add(1, 0, 2'b01, 0,    0, 0,   0, 0,  0, 0, 0,  1);
        add(1, 0, 2'b00, 0,    0, 0,   0, 0,  0, 0, 0,  P1);
        add(1, 0, 2'b01, 0,    0, 0,   0, 0,  1, 0, 0,  0);
        // Backpressure: new packet held by the router for three cycles while full.
        add(0, 0, 2'b00, 0,    1, P2,  0, 0,  1, 0, 0,  0);
        add(0, 0, 2'b00, 0,    1, 1,   0, 0,  0, 0, 0,  0);
        add(0, 0, 2'b00, 0,    1, 1,   0, 0,  0, 0, 0,  0);
        add(0, 0, 2'b00, 0,    1, 1,   0, 0,  0, 0, 0,  0);
        add(1, 0, 2'b00, 0,    1, 1,   0, 0,  0, 0, 0,  P2);
        add(1, 0, 2'b01, 0,    1, 1,   0, 0,  1, 0, 0,  0);
        add(1, 0, 2'b00, 0,    0, 0,   0, 0,  0, 0, 0,  1);
        // Send with VC=1 while polarity alternates.
        add(1, 1, 2'b10, PS,   0, 0,   1, 0,  1, 0, 0,  1);
        add(0, 0, 2'b00, 0,    0, 0,   1, 0,  1, 0, PS, 1);
        add(0, 0, 2'b00, 0,    0, 0,   1, 1,  1, 1, PS, 1);
        add(1, 0, 2'b11, 0,    0, 0,   1, 0,  1, 0, PS, 0);
        add(0, 0, 2'b00, 0,    0, 0,   1, 1,  1, 0, PS, 0);
        // Stall and drop: second store while full is discarded.
        add(1, 1, 2'b10, 3,    0, 0,   0, 0,  1, 0, PS, 0);
        add(1, 1, 2'b10, 2,    0, 0,   0, 0,  1, 0, 3,  0);
        add(1, 0, 2'b10, 0,    0, 0,   0, 0,  1, 0, 3,  3);
        add(1, 0, 2'b11, 0,    0, 0,   0, 0,  1, 0, 3,  1);
        add(0, 0, 2'b00, 0,    0, 0,   1, 0,  1, 1, 3,  1);
        add(0, 0, 2'b00, 0,    0, 0,   1, 0,  1, 0, 3,  1);
        // Store in the same cycle as a send: old packet leaves, new data dropped.
        add(1, 1, 2'b10, 5,    0, 0,   0, 0,  1, 0, 3,  1);
        add(1, 1, 2'b10, 6,    0, 0,   1, 0,  1, 1, 5,  1);
        add(1, 0, 2'b11, 0,    0, 0,   1, 0,  1, 0, 5,  0);
        add(1, 0, 2'b10, 0,    0, 0,   0, 0,  1, 0, 5,  5);
        // Stores to non-writable registers change nothing.
        add(1, 1, 2'b00, ONES, 0, 0,   0, 0,  1, 0, 5,  5);
        add(1, 1, 2'b01, ONES, 0, 0,   0, 0,  1, 0, 5,  5);
        add(1, 1, 2'b11, ONES, 0, 0,   0, 0,  1, 0, 5,  5);
        add(1, 0, 2'b01, 0,    0, 0,   0, 0,  1, 0, 5,  0);
        add(1, 0, 2'b11, 0,    0, 0,   0, 0,  1, 0, 5,  0);
        // Reading an empty input buffer returns the stale packet and keeps it empty.
        add(1, 0, 2'b00, 0,    0, 0,   0, 0,  1, 0, 5,  1);
        add(1, 0, 2'b01, 0,    0, 0,   0, 0,  1, 0, 5,  0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Polarity wait: store a VC=1 packet, then alternate polarity starting at 0.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b10, PS, 1'b0, 64'h0, 1'b1, 1'b1);
        so_count = 0;
        first_so = -1;
        so_pol   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, c[0]);
            #1;
            if (net_so) begin
                so_count++;
                if (first_so < 0) begin
                    first_so = c;
                    so_pol   = net_polarity;
                    check("pol_wait net_do", net_do, PS);
                end
            end
        end
        check("pol_wait pulse count", 64'(so_count), 64'd1);
        check("pol_wait first cycle", 64'(first_so), 64'd1);
        check("pol_wait polarity", 64'(so_pol), 64'd1);
        read_reg(2'b11, 64'h0, "pol_wait out status");

        // Reset mid-transfer discards both buffered packets.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b10, 64'h3, 1'b1, P1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst d_out", d_out, 64'h3);
        check("pre_rst net_ri", 64'(net_ri), 64'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst d_out", d_out, 64'h0);
        check("mid_rst net_ri", 64'(net_ri), 64'h1);
        check("mid_rst net_so", 64'(net_so), 64'h0);
        check("mid_rst net_do", net_do, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        read_reg(2'b01, 64'h0, "post_rst in status");
        read_reg(2'b11, 64'h0, "post_rst out status");
        read_reg(2'b00, 64'h0, "post_rst in buf");
        read_reg(2'b10, 64'h0, "post_rst out buf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
